// File: rtl/core_wb_arbiter_if.sv
// rtl/core_wb_arbiter_if.sv - Wishbone signal bundle for the two-master arbiter
// slave: arbiter side (serves m0/m1, drives the shared wb_* bus); master: requesters plus bus slave.

interface core_wb_arbiter_if #(
  parameter int ADDRESS_WIDTH = 28
);

  logic                     m0_cyc_i;
  logic                     m0_stb_i;
  logic                     m0_we_i;
  logic [3:0]               m0_sel_i;
  logic [ADDRESS_WIDTH-1:0] m0_adr_i;
  logic [31:0]              m0_data_i;
  logic                     m0_ack_o;
  logic                     m0_stall_o;
  logic                     m0_error_o;
  logic [31:0]              m0_data_o;

  logic                     m1_cyc_i;
  logic                     m1_stb_i;
  logic                     m1_we_i;
  logic [3:0]               m1_sel_i;
  logic [ADDRESS_WIDTH-1:0] m1_adr_i;
  logic [31:0]              m1_data_i;
  logic                     m1_ack_o;
  logic                     m1_stall_o;
  logic                     m1_error_o;
  logic [31:0]              m1_data_o;

  logic                     wb_cyc_o;
  logic                     wb_stb_o;
  logic                     wb_we_o;
  logic [3:0]               wb_sel_o;
  logic [ADDRESS_WIDTH-1:0] wb_adr_o;
  logic [31:0]              wb_data_o;
  logic                     wb_ack_i;
  logic                     wb_stall_i;
  logic                     wb_error_i;
  logic [31:0]              wb_data_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_data_i,
    output m0_ack_o, m0_stall_o, m0_error_o, m0_data_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_data_i,
    output m1_ack_o, m1_stall_o, m1_error_o, m1_data_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o,
    input  wb_ack_i, wb_stall_i, wb_error_i, wb_data_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_data_i,
    input  m0_ack_o, m0_stall_o, m0_error_o, m0_data_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_data_i,
    input  m1_ack_o, m1_stall_o, m1_error_o, m1_data_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o,
    output wb_ack_i, wb_stall_i, wb_error_i, wb_data_i
  );

endinterface

// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - round-robin two-master Wishbone arbiter with bus watchdog
// Grant is held for the owner's whole cycle; the data path is purely combinational.

module core_wb_arbiter #(
  parameter int ADDRESS_WIDTH  = 28,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  core_wb_arbiter_if.slave bus
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             granted;
  logic             pick;
  logic             own_cyc;
  logic             own_stb;
  logic             own_we;
  logic [3:0]       own_sel;
  logic [ADDRESS_WIDTH-1:0] own_adr;
  logic [31:0]      own_data;

  assign granted  = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
  assign own_cyc  = owner_q ? bus.m1_cyc_i  : bus.m0_cyc_i;
  assign own_stb  = owner_q ? bus.m1_stb_i  : bus.m0_stb_i;
  assign own_we   = owner_q ? bus.m1_we_i   : bus.m0_we_i;
  assign own_sel  = owner_q ? bus.m1_sel_i  : bus.m0_sel_i;
  assign own_adr  = owner_q ? bus.m1_adr_i  : bus.m0_adr_i;
  assign own_data = owner_q ? bus.m1_data_i : bus.m0_data_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Counter defaults to zero so any exit from GRANTn, ack or error clears it.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = '0;
    pick         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          pick = ~last_grant_q;
        end else begin
          pick = bus.m1_cyc_i;
        end
        if (bus.m0_cyc_i || bus.m1_cyc_i) begin
          state_d      = pick ? ST_GRANT1 : ST_GRANT0;
          owner_d      = pick;
          last_grant_d = pick;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
        end else if (WDOG_EN && !bus.wb_ack_i && !bus.wb_error_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ABORT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.wb_cyc_o   = 1'b0;
    bus.wb_stb_o   = 1'b0;
    bus.wb_we_o    = 1'b0;
    bus.wb_sel_o   = '0;
    bus.wb_adr_o   = '0;
    bus.wb_data_o  = '0;
    bus.m0_ack_o   = 1'b0;
    bus.m0_stall_o = 1'b1;
    bus.m0_error_o = 1'b0;
    bus.m0_data_o  = '1;
    bus.m1_ack_o   = 1'b0;
    bus.m1_stall_o = 1'b1;
    bus.m1_error_o = 1'b0;
    bus.m1_data_o  = '1;
    if (granted) begin
      bus.wb_cyc_o  = own_cyc;
      bus.wb_stb_o  = own_stb;
      bus.wb_we_o   = own_we;
      bus.wb_sel_o  = own_sel;
      bus.wb_adr_o  = own_adr;
      bus.wb_data_o = own_data;
      if (owner_q) begin
        bus.m1_ack_o   = bus.wb_ack_i;
        bus.m1_stall_o = bus.wb_stall_i;
        bus.m1_error_o = bus.wb_error_i;
        bus.m1_data_o  = bus.wb_data_i;
      end else begin
        bus.m0_ack_o   = bus.wb_ack_i;
        bus.m0_stall_o = bus.wb_stall_i;
        bus.m0_error_o = bus.wb_error_i;
        bus.m0_data_o  = bus.wb_data_i;
      end
    end else if (state_q == ST_ABORT) begin
      // Bus is already released; only the owner learns its cycle was killed.
      if (owner_q) begin
        bus.m1_error_o = 1'b1;
      end else begin
        bus.m0_error_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb/tb_core_wb_arbiter.sv - scoreboard bench for core_wb_arbiter
// Stimulus queues expected grants and responses; a negedge monitor pops and compares them.

module tb_core_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core_wb_arbiter_if #(.ADDRESS_WIDTH(28)) bus ();

  core_wb_arbiter #(
    .ADDRESS_WIDTH (28),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [27:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wd;
    int          gap;
  } grant_t;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] data;
    int          lat;
    logic        abrt;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     slave_delay = 0;
  bit     slave_err = 1'b0;
  bit     kill_xfer = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void exp_grant(input logic [27:0] adr, input logic we, input logic [3:0] sel,
                                    input logic [31:0] wd, input int gap);
    grant_t g;
    g.adr = adr; g.we = we; g.sel = sel; g.wd = wd; g.gap = gap;
    gq.push_back(g);
  endfunction

  function automatic void exp_resp(input int m, input logic err, input logic [31:0] data,
                                   input int lat, input logic abrt);
    resp_t r;
    r.m = m; r.err = err; r.data = data; r.lat = lat; r.abrt = abrt;
    rq.push_back(r);
  endfunction

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [27:0] adr, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_we_i = we;
      bus.m0_sel_i = sel; bus.m0_adr_i = adr; bus.m0_data_i = wd;
    end else begin
      bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_we_i = we;
      bus.m1_sel_i = sel; bus.m1_adr_i = adr; bus.m1_data_i = wd;
    end
  endtask

  task automatic set_cs(input int m, input logic cyc, input logic stb);
    if (m == 0) begin
      bus.m0_cyc_i = cyc; bus.m0_stb_i = stb;
    end else begin
      bus.m1_cyc_i = cyc; bus.m1_stb_i = stb;
    end
  endtask

  // One pipelined transfer: stb until accepted, cyc until ack or error.
  task automatic xfer(input int m, input logic [27:0] adr, input logic we,
                      input logic [3:0] sel, input logic [31:0] wd);
    int   n;
    logic accepted, done, st, rsp;
    n = 0; accepted = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    drive(m, 1'b1, 1'b1, we, sel, adr, wd);
    while (!done && !kill_xfer && n < 200) begin
      @(negedge clk);
      n++;
      st  = (m == 0) ? bus.m0_stall_o : bus.m1_stall_o;
      rsp = (m == 0) ? (bus.m0_ack_o | bus.m0_error_o) : (bus.m1_ack_o | bus.m1_error_o);
      if (rsp) done = 1'b1;
      else if (!st) accepted = 1'b1;
      @(posedge clk); #1;
      if (done) set_cs(m, 1'b0, 1'b0);
      else if (accepted) set_cs(m, 1'b1, 1'b0);
    end
    if (!done) begin
      set_cs(m, 1'b0, 1'b0);
      if (!kill_xfer) begin
        n_checks++;
        n_errors++;
        $display("FAIL xfer_bound: m%0d adr %0h got no response, required one within 200 cycles", m, adr);
      end
    end
  endtask

  // Slave: acks (or errors) once per cycle, slave_delay+1 cycles after wb_cyc_o rises.
  initial begin : slave
    int          cnt;
    logic        fire, done_cyc;
    logic [27:0] a;
    cnt = 0; done_cyc = 1'b0; a = '0;
    bus.wb_ack_i = 1'b0; bus.wb_stall_i = 1'b0; bus.wb_error_i = 1'b0; bus.wb_data_i = '0;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (bus.wb_cyc_o) begin
        if (!done_cyc && slave_delay >= 0 && cnt == slave_delay) begin
          fire = 1'b1;
          done_cyc = 1'b1;
        end
        cnt++;
        a = bus.wb_adr_o;
      end else begin
        cnt = 0;
        done_cyc = 1'b0;
      end
      @(posedge clk); #1;
      bus.wb_ack_i   = fire && !slave_err;
      bus.wb_error_i = fire && slave_err;
      bus.wb_data_i  = fire ? {4'hA, a} : 32'h0;
    end
  end

  initial begin : monitor
    logic   prev_cyc, r0, r1;
    int     gap, since;
    bit     have;
    grant_t cur;
    resp_t  e;
    prev_cyc = 1'b0; gap = 0; since = 0; have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cyc = 1'b0; gap = 0; have = 1'b0;
      end else begin
        since++;
        if (bus.wb_cyc_o && !prev_cyc) begin
          since = 0;
          if (gq.size() == 0) begin
            n_checks++;
            n_errors++;
            have = 1'b0;
            $display("FAIL unexpected_grant: wb_adr_o %0h, required no grant", bus.wb_adr_o);
          end else begin
            cur  = gq.pop_front();
            have = 1'b1;
            chk("grant_gap", 64'(gap), 64'(cur.gap));
          end
          gap = 0;
        end
        if (bus.wb_cyc_o && have) begin
          chk("mirror_adr", 64'(bus.wb_adr_o), 64'(cur.adr));
          chk("mirror_we", 64'(bus.wb_we_o), 64'(cur.we));
          chk("mirror_sel", 64'(bus.wb_sel_o), 64'(cur.sel));
          chk("mirror_data", 64'(bus.wb_data_o), 64'(cur.wd));
        end else if (!bus.wb_cyc_o && (bus.m0_cyc_i || bus.m1_cyc_i)) begin
          gap++;
        end
        r0 = bus.m0_ack_o | bus.m0_error_o;
        r1 = bus.m1_ack_o | bus.m1_error_o;
        if (r0 && r1) begin
          n_checks++;
          n_errors++;
          $display("FAIL both_resp: m0 and m1 both see ack/error, required at most one");
        end else if (r0 || r1) begin
          if (rq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp: m%0d ack/error seen, required none", r1 ? 1 : 0);
          end else begin
            e = rq.pop_front();
            chk("resp_master", 64'(r1), 64'(e.m));
            chk("resp_err", 64'(r1 ? bus.m1_error_o : bus.m0_error_o), 64'(e.err));
            chk("resp_ack", 64'(r1 ? bus.m1_ack_o : bus.m0_ack_o), 64'(!e.err));
            if (!e.err) chk("resp_data", 64'(r1 ? bus.m1_data_o : bus.m0_data_o), 64'(e.data));
            chk("resp_latency", 64'(since), 64'(e.lat));
            if (e.abrt) chk("abort_wb_cyc", 64'(bus.wb_cyc_o), 64'(0));
          end
        end
        prev_cyc = bus.wb_cyc_o;
      end
    end
  end

  initial begin : stimulus
    logic [27:0] a0, a1;
    logic [31:0] d1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 28'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 28'h0, 32'h0);

    // Both request during reset: m0 must win the first tie.
    exp_grant(28'h0000100, 1'b0, 4'hF, 32'h0, 1);
    exp_grant(28'h0001000, 1'b0, 4'hF, 32'h0, 2);
    exp_resp(0, 1'b0, 32'hA0000100, 1, 1'b0);
    exp_resp(1, 1'b0, 32'hA0001000, 1, 1'b0);
    fork
      xfer(0, 28'h0000100, 1'b0, 4'hF, 32'h0);
      xfer(1, 28'h0001000, 1'b0, 4'hF, 32'h0);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_cyc_held", 64'(bus.m0_cyc_i), 64'(1));
        chk("rst_wb_cyc", 64'(bus.wb_cyc_o), 64'(0));
        chk("rst_wb_stb", 64'(bus.wb_stb_o), 64'(0));
        chk("rst_wb_we", 64'(bus.wb_we_o), 64'(0));
        chk("rst_wb_sel", 64'(bus.wb_sel_o), 64'(0));
        chk("rst_wb_adr", 64'(bus.wb_adr_o), 64'(0));
        chk("rst_wb_data", 64'(bus.wb_data_o), 64'(0));
        chk("rst_m0_stall", 64'(bus.m0_stall_o), 64'(1));
        chk("rst_m1_stall", 64'(bus.m1_stall_o), 64'(1));
        chk("rst_m0_ack_err", 64'({bus.m0_ack_o, bus.m0_error_o}), 64'(0));
        chk("rst_m1_ack_err", 64'({bus.m1_ack_o, bus.m1_error_o}), 64'(0));
        chk("rst_m0_data", 64'(bus.m0_data_o), 64'(32'hFFFF_FFFF));
        chk("rst_m1_data", 64'(bus.m1_data_o), 64'(32'hFFFF_FFFF));
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    join

    // m1 write, slave acks on the third cycle of the grant.
    slave_delay = 2;
    exp_grant(28'h0002000, 1'b1, 4'b0011, 32'hDEADBEEF, 1);
    exp_resp(1, 1'b0, 32'hA0002000, 3, 1'b0);
    xfer(1, 28'h0002000, 1'b1, 4'b0011, 32'hDEADBEEF);
    slave_delay = 0;

    // Simultaneous requests: m0 then m1 every round, one IDLE between grants.
    for (int i = 0; i < 4; i++) begin
      a0 = 28'h0000200 + 28'(i * 4);
      a1 = 28'h0003000 + 28'(i * 4);
      d1 = 32'h1111_0000 + 32'(i);
      exp_grant(a0, 1'b0, 4'hF, 32'h0, 1);
      exp_grant(a1, 1'b1, 4'hC, d1, 2);
      exp_resp(0, 1'b0, {4'hA, a0}, 1, 1'b0);
      exp_resp(1, 1'b0, {4'hA, a1}, 1, 1'b0);
      fork
        xfer(0, a0, 1'b0, 4'hF, 32'h0);
        xfer(1, a1, 1'b1, 4'hC, d1);
      join
    end

    // Slave error is passed straight through to the owner.
    slave_err = 1'b1;
    slave_delay = 1;
    exp_grant(28'h0004000, 1'b0, 4'hF, 32'h0, 1);
    exp_resp(1, 1'b1, 32'h0, 2, 1'b0);
    xfer(1, 28'h0004000, 1'b0, 4'hF, 32'h0);
    slave_err = 1'b0;

    // Watchdog: 8 unanswered cycles, ABORT, then the waiting m1 is granted.
    slave_delay = -1;
    exp_grant(28'h0005000, 1'b0, 4'hF, 32'h0, 1);
    exp_grant(28'h0006000, 1'b1, 4'h3, 32'hCAFEF00D, 2);
    exp_resp(0, 1'b1, 32'h0, 8, 1'b1);
    exp_resp(1, 1'b0, 32'hA0006000, 1, 1'b0);
    fork
      begin
        xfer(0, 28'h0005000, 1'b0, 4'hF, 32'h0);
        slave_delay = 0;
      end
      xfer(1, 28'h0006000, 1'b1, 4'h3, 32'hCAFEF00D);
    join

    // Ack on the 8th counted cycle beats the watchdog.
    slave_delay = 6;
    exp_grant(28'h0007000, 1'b0, 4'hF, 32'h0, 1);
    exp_resp(0, 1'b0, 32'hA0007000, 7, 1'b0);
    xfer(0, 28'h0007000, 1'b0, 4'hF, 32'h0);

    // Reset in the middle of an m1 cycle.
    slave_delay = -1;
    exp_grant(28'h0008000, 1'b1, 4'hF, 32'h12345678, 1);
    fork
      xfer(1, 28'h0008000, 1'b1, 4'hF, 32'h12345678);
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_wb_cyc", 64'(bus.wb_cyc_o), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_cyc", 64'(bus.wb_cyc_o), 64'(0));
        chk("midrst_wb_stb", 64'(bus.wb_stb_o), 64'(0));
        chk("midrst_m1_ack_err", 64'({bus.m1_ack_o, bus.m1_error_o}), 64'(0));
        chk("midrst_m1_stall", 64'(bus.m1_stall_o), 64'(1));
        kill_xfer = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    kill_xfer = 1'b0;
    slave_delay = 0;
    rst_n = 1'b1;

    exp_grant(28'h0009000, 1'b0, 4'hF, 32'h0, 1);
    exp_grant(28'h000A000, 1'b0, 4'hF, 32'h0, 2);
    exp_resp(0, 1'b0, 32'hA0009000, 1, 1'b0);
    exp_resp(1, 1'b0, 32'hA000A000, 1, 1'b0);
    fork
      xfer(0, 28'h0009000, 1'b0, 4'hF, 32'h0);
      xfer(1, 28'h000A000, 1'b0, 4'hF, 32'h0);
    join

    repeat (5) @(posedge clk);
    chk("grants_left", 64'(gq.size()), 64'(0));
    chk("resps_left", 64'(rq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

endmodule

// File: doc/core_wb_arbiter.md
Name: core_wb_arbiter

Overview:
- Two-master to one-master Wishbone arbiter in front of the core's system bus port.
- Lets the instruction-fetch interface (m0) and the data/load-store interface (m1) share a single Wishbone master connection to the interconnect.
- Round-robin grant, held for the whole cycle (cyc) of the owner.
- Bus watchdog aborts transactions that get no ack or error within a set number of cycles.

Parameters:
- ADDRESS_WIDTH, 28: Wishbone address width on all ports.
- TIMEOUT_CYCLES, 64: cycles with no ack or error before the watchdog aborts; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (fetch) bus control.
- m0_sel_i  in  4  master 0 byte select.
- m0_adr_i  in  ADDRESS_WIDTH  master 0 address.
- m0_data_i  in  32  master 0 write data.
- m0_ack_o, m0_stall_o, m0_error_o  out  1 each  master 0 responses.
- m0_data_o  out  32  master 0 read data.
- m1_*: the same set as m0_* for master 1 (data port).
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  shared bus control.
- wb_sel_o  out  4  shared byte select.
- wb_adr_o  out  ADDRESS_WIDTH  shared address.
- wb_data_o  out  32  shared write data.
- wb_ack_i, wb_stall_i, wb_error_i  in  1 each  slave responses.
- wb_data_i  in  32  slave read data.

Behaviour:
- States: IDLE, GRANT0, GRANT1, ABORT. Registers: state, owner (1 bit), lastGrant (1 bit), timeout counter of width clog2(TIMEOUT_CYCLES+1).
- Reset (asynchronous, wb_rst_n_i low): state=IDLE, lastGrant=1 so m0 wins the first tie, counter=0.
- Outputs during and after reset: wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_data_o=0; both mX_ack_o=0 and mX_error_o=0; both mX_stall_o=1; both mX_data_o=~32'b0.
- A reset asserted mid-transaction drops wb_cyc_o immediately (combinational path from state), with no ack and no error.
- IDLE:
  - Nothing is forwarded; both stalls are 1.
  - Only m0_cyc_i high: next state GRANT0. Only m1_cyc_i high: next state GRANT1.
  - Both high: grant the master that is not lastGrant.
  - On any grant, lastGrant and owner take the granted index.
  - Arbitration latency is exactly 1 cycle from cyc rising to the grant.
- GRANTn:
  - Combinationally forward the owner's cyc, stb, we, sel, adr and data to the wb_* outputs.
  - Route wb_ack_i, wb_stall_i, wb_error_i and wb_data_i to the owner.
  - The non-owner sees stall=1, ack=0, error=0, data=~32'b0.
- Release: at the clock edge where the owner's cyc_i is low, state goes to IDLE.
  - There is always at least one IDLE cycle between grants, so there are no back-to-back ownership changes.
  - A master that drops and re-raises cyc competes again under round-robin, so a waiting master is guaranteed the next grant.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each cycle in GRANTn with wb_cyc_o=1 and wb_ack_i=0 and wb_error_i=0.
  - It clears on ack, on error, or on leaving GRANTn.
  - When the counter equals TIMEOUT_CYCLES-1 and there is still no ack or error, next state is ABORT.
  - Ack and timeout arriving on the same cycle: the ack wins and the counter clears.
- ABORT (exactly 1 cycle):
  - wb_cyc_o=0 and wb_stb_o=0.
  - Owner gets error=1, ack=0, stall=1; the other master gets stall=1.
  - Then IDLE, regardless of the owner's cyc.
- wb_error_i in GRANTn is passed through to the owner and does not itself change state; the owner ends the cycle.
- No buffering in the data path: ack, data and error to the owner are zero-latency, combinational relative to wb_*.
- The arbiter never asserts ack or error to a master that does not own the bus.

Test Plan:
- Reset with m0_cyc_i=1 held -> wb_cyc_o=0, both stalls=1; first edge after release -> GRANT0, with wb_adr_o=m0_adr_i (e.g. 0x0000100) the next cycle.
- m0 and m1 raise cyc on the same cycle, each doing 1 transfer, repeated 4 times -> grant order is m0, m1, m0, m1, with exactly one IDLE cycle between grants.
- m1 write to adr 0x0002000, data 0xDEADBEEF, sel 4'b0011; slave acks after 3 cycles -> the wb_* outputs mirror m1 throughout, m1_ack_o pulses once, and m0_ack_o stays 0.
- TIMEOUT_CYCLES=8, slave never acks m0 -> 8 counted cycles, then one ABORT cycle with m0_error_o=1 and wb_cyc_o=0, then IDLE; m1 is granted next if it is requesting.
- Slave acks on exactly the 8th counted cycle -> no ABORT, m0_ack_o=1, counter cleared.
- Reset asserted mid-transaction of m1 -> wb_cyc_o=0 the same cycle, no ack or error to m1; after release m0 wins a tie.
